// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : word-organised data RAM answering core load/store requests
// after WAIT_CYCLES wait states. Optional macro: DMEM_MISALIGN_CHECK_EN.
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [31:0] d_add,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  f3,
  input  logic [4:0]  req_rd,
  output logic        d_busy,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        wb_en,
  output logic [4:0]  wb_rd
);

  localparam int         AW          = $clog2(DEPTH);
  localparam int         WAIT_LOAD   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_LOAD);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] add_q, add_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        ld_op_q, ld_op_d;
  logic        st_op_q, st_op_d;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          oor;
  logic          misalign;
  logic          f3_ok;
  logic          err;
  logic [1:0]    off;
  logic [31:0]   rword;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   st_lanes;
  logic [31:0]   mem_wdata_d;
  logic          mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      add_q   <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      ld_op_q <= 1'b0;
      st_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      ld_op_q <= ld_op_d;
      st_op_q <= st_op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    add_d   = add_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    ld_op_d = ld_op_q;
    st_op_d = st_op_q;
    case (state_q)
      IDLE: begin
        if (d_r_en || d_w_en) begin
          add_d   = d_add;
          wdata_d = d_wdata;
          f3_d    = f3;
          rd_d    = req_rd;
          ld_op_d = d_r_en;
          st_op_d = d_w_en;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = C_WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx = add_q[AW+1:2];
  assign oor = |add_q[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((f3_q[1:0] == 2'b01) && add_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (add_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    if (st_op_q) f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    else         f3_ok = (f3_q != 3'b011) && (f3_q != 3'b110) && (f3_q != 3'b111);
  end

  assign err = (ld_op_q && st_op_q) || oor || !f3_ok || misalign;

  // Low offset bits below the access size are dropped; a flagged misalign errors out anyway.
  always_comb begin
    case (f3_q[1:0])
      2'b01:   off = {add_q[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = add_q[1:0];
    endcase
  end

  assign rword   = mem_q[idx];
  assign shifted = rword >> {off, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = rword;
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << off;
        st_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << off;
        st_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        st_lanes = wdata_q;
      end
    endcase
    mem_wdata_d = rword;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_wdata_d[8*i +: 8] = st_lanes[8*i +: 8];
    end
  end

  assign mem_we = (state_q == RESP) && st_op_q && !err;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_wdata_d;
  end

  assign d_valid = (state_q == RESP);
  assign d_busy  = (state_q != IDLE);
  assign d_err   = d_valid && err;
  assign d_rdata = (d_valid && ld_op_q && !err) ? ld_data : 32'd0;
  assign wb_en   = d_valid && ld_op_q && !err && (rd_q != 5'd0);
  assign wb_rd   = wb_en ? rd_q : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed plus random load/store traffic against a
// byte-level reference model; a second instance covers held-request throughput.
// Revision 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int WAITC  = 1;
  localparam int DEPTH3 = 16;

  logic        clk;
  logic        rst_n;
  logic        d_r_en, d_w_en;
  logic [31:0] d_add, d_wdata;
  logic [2:0]  f3;
  logic [4:0]  req_rd;
  logic        d_busy, d_valid, d_err, wb_en;
  logic [31:0] d_rdata;
  logic [4:0]  wb_rd;

  logic        r3;
  logic        busy3, valid3, err3, wb_en3;
  logic [31:0] rdata3;
  logic [4:0]  wb_rd3;

  int n_pass  = 0;
  int n_total = 0;

  bit [31:0] ref_mem [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .d_r_en(d_r_en), .d_w_en(d_w_en), .d_add(d_add),
    .d_wdata(d_wdata), .f3(f3), .req_rd(req_rd), .d_busy(d_busy), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err), .wb_en(wb_en), .wb_rd(wb_rd)
  );

  dmem_responder #(.DEPTH(DEPTH3), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .d_r_en(r3), .d_w_en(1'b0), .d_add(32'd0),
    .d_wdata(32'd0), .f3(3'b010), .req_rd(5'd1), .d_busy(busy3), .d_valid(valid3),
    .d_rdata(rdata3), .d_err(err3), .wb_en(wb_en3), .wb_rd(wb_rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Reference: byte-lane view of memory, sizes and signedness straight from funct3.
  function automatic void model(input bit r, input bit w, input bit [31:0] a,
                                input bit [31:0] wd, input bit [2:0] f, input bit [4:0] rd,
                                output bit err, output bit [31:0] rdata,
                                output bit wb, output bit [4:0] wbrd);
    int        size;
    int        off;
    int        idx;
    bit        legal;
    bit [31:0] word;
    bit [31:0] mask;
    bit [31:0] val;
    err = 0; rdata = 0; wb = 0; wbrd = 0;
    size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : (f[1:0] == 2'd2) ? 4 : 0;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (r && w) err = 1;
    if (!legal) err = 1;
    if (a >= 32'(4 * DEPTH)) err = 1;
    off = int'(a % 4);
    if (size > 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      if (off % size != 0) err = 1;
`endif
      off = off - (off % size);
    end
    if (err) return;
    idx  = int'(a / 4);
    word = ref_mem[idx];
    if (w) begin
      for (int b = 0; b < size; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[idx] = word;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 1);
      val  = (word >> (8*off)) & mask;
      if (!f[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      rdata = val;
      wb    = (rd != 0);
      wbrd  = wb ? rd : 5'd0;
    end
  endfunction

  task automatic do_req(input bit r, input bit w, input bit [31:0] a, input bit [31:0] wd,
                        input bit [2:0] f, input bit [4:0] rd, input string tag);
    bit        e_err, e_wb;
    bit [31:0] e_rdata;
    bit [4:0]  e_wbrd;
    int        lat;
    model(r, w, a, wd, f, rd, e_err, e_rdata, e_wb, e_wbrd);
    @(negedge clk);
    d_r_en = r; d_w_en = w; d_add = a; d_wdata = wd; f3 = f; req_rd = rd;
    @(posedge clk);
    #1;
    d_r_en = 1'b0; d_w_en = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d_valid && lat < 20);
    check({tag, ".latency"}, 32'(lat), 32'(WAITC + 1));
    check({tag, ".busy"},    {31'd0, d_busy}, 32'd1);
    check({tag, ".err"},     {31'd0, d_err},  {31'd0, e_err});
    check({tag, ".rdata"},   d_rdata, e_rdata);
    check({tag, ".wb_en"},   {31'd0, wb_en},  {31'd0, e_wb});
    check({tag, ".wb_rd"},   {27'd0, wb_rd},  {27'd0, e_wbrd});
    @(negedge clk);
    check({tag, ".pulse"},   {30'd0, d_valid, d_busy}, 32'd0);
  endtask

  initial begin
    bit [31:0] a;
    int        kind;
    rst_n = 1'b0; d_r_en = 0; d_w_en = 0; d_add = 0; d_wdata = 0; f3 = 0; req_rd = 0; r3 = 0;
    repeat (3) @(negedge clk);
    check("reset.outs", {d_busy, d_valid, d_err, wb_en, wb_rd, d_rdata[22:0]}, 32'd0);
    check("reset.rdata", d_rdata, 32'd0);
    rst_n = 1'b1;

    do_req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, "sw10");
    do_req(1, 0, 32'h10, 32'h0,        3'b010, 5, "lw10");
    do_req(0, 1, 32'h12, 32'h000000AA, 3'b000, 0, "sb12");
    do_req(0, 1, 32'h10, 32'h00001234, 3'b001, 0, "sh10");
    do_req(1, 0, 32'h10, 32'h0,        3'b010, 7, "lw10_masked");
    check("lane_mask.model", ref_mem[4], 32'hDEAA1234);

    do_req(0, 1, 32'h20, 32'h80FF7F01, 3'b010, 0, "sw20");
    do_req(1, 0, 32'h20, 0, 3'b000, 1, "lb20");
    do_req(1, 0, 32'h22, 0, 3'b000, 2, "lb22");
    do_req(1, 0, 32'h23, 0, 3'b100, 3, "lbu23");
    do_req(1, 0, 32'h22, 0, 3'b001, 4, "lh22");
    do_req(1, 0, 32'h22, 0, 3'b101, 6, "lhu22");

    do_req(0, 1, 32'h0, 32'h01020304, 3'b010, 0, "sw0");
    do_req(0, 1, 32'(4*DEPTH), 32'hFFFFFFFF, 3'b010, 0, "sw_oor");
    do_req(1, 0, 32'(4*DEPTH), 0, 3'b010, 8, "lw_oor");
    do_req(1, 0, 32'h0, 0, 3'b010, 9, "lw0_after_oor");
    do_req(1, 0, 32'h10, 0, 3'b011, 10, "ld_f3_011");
    do_req(1, 1, 32'h10, 32'h5A5A5A5A, 3'b010, 11, "both_en");
    do_req(1, 0, 32'h10, 0, 3'b010, 0, "lw_rd0");
    do_req(1, 0, 32'h11, 0, 3'b010, 12, "lw11_misalign");

    // Abort a store in its wait state; memory must keep the old word.
    do_req(0, 1, 32'h30, 32'h11223344, 3'b010, 0, "sw30");
    @(negedge clk);
    d_w_en = 1; d_add = 32'h30; d_wdata = 32'h55; f3 = 3'b010;
    @(posedge clk);
    #1 d_w_en = 0;
    @(negedge clk);
    check("abort.busy_before", {31'd0, d_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy_cleared", {31'd0, d_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.no_valid", {31'd0, d_valid}, 32'd0);
    end
    rst_n = 1'b1;
    do_req(1, 0, 32'h30, 0, 3'b010, 13, "lw30_after_abort");

    for (int i = 0; i < 16; i++)
      do_req(0, 1, 32'(4*i), $urandom, 3'b010, 0, "rnd_init");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 15);
      a    = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH) + $urandom_range(0, 255)
                                         : 32'($urandom_range(0, 63));
      do_req(kind >= 8 || kind == 0, kind < 8, a, $urandom,
             3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), "rnd");
    end

    // Held request on the 3-wait-state instance: one acceptance every 5 cycles.
    @(negedge clk);
    r3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("hold.busy",  {31'd0, busy3},  {31'd0, (k % 5) != 0});
      check("hold.valid", {31'd0, valid3}, {31'd0, (k % 5) == 4});
    end
    r3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
